// File: rtl/ddr_read_arbiter.sv
// Round-robin, burst-locked arbiter sharing one external read port among instr/feat/weight fetchers.
// Define ARB_PERF_CNT_EN to add per-master beat counters and a stall-cycle counter.
module ddr_read_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 128,
  parameter int NARROW_WIDTH = 64,
  parameter int RD_LATENCY   = 1,
  parameter int MAX_BURST    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_req,
  input  logic [ADDR_WIDTH-1:0]   instr_addr,
  output logic [NARROW_WIDTH-1:0] instr_data,
  output logic                    instr_valid,
  input  logic                    feat_req,
  input  logic [ADDR_WIDTH-1:0]   feat_addr,
  output logic [DATA_WIDTH-1:0]   feat_data,
  output logic                    feat_valid,
  input  logic                    w_req,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  output logic [NARROW_WIDTH-1:0] w_data,
  output logic                    w_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd_en,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  output logic [1:0]              grant_id,
  output logic                    busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]             perf_instr_beats,
  output logic [31:0]             perf_feat_beats,
  output logic [31:0]             perf_w_beats,
  output logic [31:0]             perf_stall_cycles
`endif
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nx;
  logic [1:0]        owner, owner_nx;
  logic [1:0]        last_owner, last_nx;
  logic [CNT_W-1:0]  burst_cnt, burst_nx;

  logic [3:0]        req_vec;
  logic              owner_req;
  logic              issue;
  logic              release_now;
  logic              arbitrate;
  logic [1:0]        scan_base, cand1, cand2, pick;
  logic              found;

  logic [RD_LATENCY-1:0] tag_vld;
  logic [1:0]            tag_own [RD_LATENCY];
  logic                  ret_vld;
  logic [1:0]            ret_own;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign req_vec   = {1'b0, w_req, feat_req, instr_req};
  assign owner_req = req_vec[owner];
  assign issue     = (state == GRANT) && owner_req;
  // Releasing on the last beat lets the next owner issue on the very next cycle.
  assign release_now = (state == GRANT) &&
                       (!owner_req || (burst_cnt == CNT_W'(MAX_BURST - 1)));
  assign arbitrate = (state == IDLE) || release_now;
  assign scan_base = release_now ? owner : last_owner;
  assign cand1     = inc3(scan_base);
  assign cand2     = inc3(cand1);

  always_comb begin
    found = 1'b1;
    pick  = 2'd0;
    if (req_vec[cand1])          pick = cand1;
    else if (req_vec[cand2])     pick = cand2;
    else if (req_vec[scan_base]) pick = scan_base;
    else                         found = 1'b0;
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last_owner;
    burst_nx = burst_cnt;
    if (issue) burst_nx = burst_cnt + CNT_W'(1);
    if (release_now) last_nx = owner;
    if (arbitrate) begin
      burst_nx = '0;
      if (found) begin
        state_nx = GRANT;
        owner_nx = pick;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_nx;
      burst_cnt  <= burst_nx;
    end
  end

  always_comb begin
    mem_addr = '0;
    if (issue) begin
      case (owner)
        2'd0:    mem_addr = instr_addr;
        2'd1:    mem_addr = feat_addr;
        2'd2:    mem_addr = w_addr;
        default: mem_addr = '0;
      endcase
    end
  end

  assign mem_rd_en = issue;
  assign grant_id  = (state == GRANT) ? owner : 2'd3;

  // Each stage carries {vld, owner} so returned beats are steered without lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_own[i] <= 2'd0;
    end else begin
      tag_vld[0] <= issue;
      tag_own[0] <= owner;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  assign ret_vld     = tag_vld[RD_LATENCY-1];
  assign ret_own     = tag_own[RD_LATENCY-1];
  assign busy        = |tag_vld;
  assign instr_valid = ret_vld && (ret_own == 2'd0);
  assign feat_valid  = ret_vld && (ret_own == 2'd1);
  assign w_valid     = ret_vld && (ret_own == 2'd2);
  assign instr_data  = instr_valid ? mem_data[NARROW_WIDTH-1:0] : '0;
  assign feat_data   = feat_valid  ? mem_data : '0;
  assign w_data      = w_valid     ? mem_data[NARROW_WIDTH-1:0] : '0;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_instr_beats  <= '0;
      perf_feat_beats   <= '0;
      perf_w_beats      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (issue && owner == 2'd0 && perf_instr_beats != '1) perf_instr_beats <= perf_instr_beats + 32'd1;
      if (issue && owner == 2'd1 && perf_feat_beats  != '1) perf_feat_beats  <= perf_feat_beats + 32'd1;
      if (issue && owner == 2'd2 && perf_w_beats     != '1) perf_w_beats     <= perf_w_beats + 32'd1;
      if ((|req_vec) && !issue && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Bench for ddr_read_arbiter: directed vector table, reset-mid-burst sequence, and random
// traffic checked against a cycle-level arbitration model (RD_LATENCY=3, MAX_BURST=4).
module tb_ddr_read_arbiter;
  localparam int AW = 16, DW = 128, NW = 64, LAT = 3, MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_req = 1'b0, feat_req = 1'b0, w_req = 1'b0;
  logic [AW-1:0] instr_addr = '0, feat_addr = '0, w_addr = '0;
  logic [NW-1:0] instr_data, w_data;
  logic [DW-1:0] feat_data;
  logic instr_valid, feat_valid, w_valid;
  logic [AW-1:0] mem_addr;
  logic mem_rd_en;
  logic [DW-1:0] mem_data = '0;
  logic [1:0] grant_id;
  logic busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_instr_beats, perf_feat_beats, perf_w_beats, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  ddr_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NARROW_WIDTH(NW),
                     .RD_LATENCY(LAT), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_data(instr_data), .instr_valid(instr_valid),
    .feat_req(feat_req), .feat_addr(feat_addr), .feat_data(feat_data), .feat_valid(feat_valid),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .grant_id(grant_id), .busy(busy)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_instr_beats(perf_instr_beats), .perf_feat_beats(perf_feat_beats),
    .perf_w_beats(perf_w_beats), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] req;  // {w, feat, instr}
    logic       rs;
    logic       ck;
    logic [1:0] g;
    logic       en;
    logic [2:0] v;    // {w_valid, feat_valid, instr_valid}
    logic       b;
  } vec_t;

  vec_t tbl [30];

  // Reference model state
  int m_owner, m_cnt, m_last, m_stall;
  int m_beats [3];
  logic [2:0] exp_q [$];   // {vld, owner} per in-flight slot, oldest first

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [1:0] g);
    case (g)
      2'd0:    return instr_addr;
      2'd1:    return feat_addr;
      2'd2:    return w_addr;
      default: return '0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [2:0] r, input logic rs, input logic ck, input logic [1:0] g,
                              input logic en, input logic [2:0] v, input logic b);
    vec_t t;
    t.req = r; t.rs = rs; t.ck = ck; t.g = g; t.en = en; t.v = v; t.b = b;
    return t;
  endfunction

  task automatic drive(input logic [2:0] r, input logic rs);
    @(posedge clk);
    #1;
    rst        = rs;
    instr_req  = r[0];
    feat_req   = r[1];
    w_req      = r[2];
    instr_addr = AW'($urandom());
    feat_addr  = AW'($urandom());
    w_addr     = AW'($urandom());
    mem_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
  endtask

  task automatic check_cycle(input string nm, input logic [1:0] eg, input logic er,
                             input logic [2:0] ev, input logic eb);
    logic [AW-1:0] ea;
    ea = er ? addr_of(eg) : '0;
    chk({nm, ".grant"}, 128'(grant_id), 128'(eg));
    chk({nm, ".rd_en"}, 128'(mem_rd_en), 128'(er));
    chk({nm, ".addr"}, 128'(mem_addr), 128'(ea));
    chk({nm, ".valids"}, 128'({w_valid, feat_valid, instr_valid}), 128'(ev));
    chk({nm, ".busy"}, 128'(busy), 128'(eb));
    chk({nm, ".instr_data"}, 128'(instr_data), ev[0] ? 128'(mem_data[NW-1:0]) : 128'd0);
    chk({nm, ".feat_data"}, feat_data, ev[1] ? mem_data : 128'd0);
    chk({nm, ".w_data"}, 128'(w_data), ev[2] ? 128'(mem_data[NW-1:0]) : 128'd0);
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 2; m_stall = 0;
    for (int i = 0; i < 3; i++) m_beats[i] = 0;
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back(3'b000);
  endtask

  // One cycle of the model: check what the port must show now, then apply the clock edge.
  task automatic model_step(input logic rs);
    logic [2:0] r, front, ev;
    logic iss, bz;
    r     = {w_req, feat_req, instr_req};
    iss   = (m_owner >= 0) && r[m_owner];
    front = exp_q[0];
    ev    = front[2] ? 3'(3'b001 << front[1:0]) : 3'b000;
    bz    = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][2]) bz = 1'b1;
    check_cycle("rnd", (m_owner < 0) ? 2'd3 : 2'(m_owner), iss, ev, bz);
    if (rs) begin
      model_reset();
      return;
    end
    if (iss) m_beats[m_owner]++;
    if (r != 3'b000 && !iss) m_stall++;
    void'(exp_q.pop_front());
    exp_q.push_back({iss, iss ? 2'(m_owner) : 2'd0});
    if (m_owner < 0 || !r[m_owner] || (iss && m_cnt + 1 == MB)) begin
      if (m_owner >= 0) m_last = m_owner;
      m_owner = -1;
      for (int k = 1; k <= 3; k++)
        if (m_owner < 0 && r[(m_last + k) % 3]) m_owner = (m_last + k) % 3;
      m_cnt = 0;
    end else if (iss) begin
      m_cnt++;
    end
  endtask

  initial begin
    logic [2:0] cur;
    logic rs;

    // All three requesting: 4 beats each in order instr, feat, weight, then back to instr.
    tbl[0] = mk(3'b111, 0, 1, 2'd3, 0, 3'b000, 0);
    for (int i = 1; i <= 3; i++)  tbl[i] = mk(3'b111, 0, 1, 2'd0, 1, 3'b000, i > 1);
    tbl[4] = mk(3'b111, 0, 1, 2'd0, 1, 3'b001, 1);
    for (int i = 5; i <= 7; i++)  tbl[i] = mk(3'b111, 0, 1, 2'd1, 1, 3'b001, 1);
    tbl[8] = mk(3'b111, 0, 1, 2'd1, 1, 3'b010, 1);
    for (int i = 9; i <= 11; i++) tbl[i] = mk(3'b111, 0, 1, 2'd2, 1, 3'b010, 1);
    tbl[12] = mk(3'b111, 0, 1, 2'd2, 1, 3'b100, 1);
    tbl[13] = mk(3'b111, 0, 1, 2'd0, 1, 3'b100, 1);
    tbl[14] = mk(3'b000, 0, 1, 2'd0, 0, 3'b100, 1);
    tbl[15] = mk(3'b000, 0, 1, 2'd3, 0, 3'b100, 1);
    tbl[16] = mk(3'b000, 0, 1, 2'd3, 0, 3'b001, 1);
    tbl[17] = mk(3'b000, 0, 1, 2'd3, 0, 3'b000, 0);
    // Reset while two instr beats are in flight: they must never come back.
    tbl[18] = mk(3'b000, 1, 0, 2'd3, 0, 3'b000, 0);
    tbl[19] = mk(3'b001, 0, 1, 2'd3, 0, 3'b000, 0);
    tbl[20] = mk(3'b001, 0, 1, 2'd0, 1, 3'b000, 0);
    tbl[21] = mk(3'b001, 0, 1, 2'd0, 1, 3'b000, 1);
    tbl[22] = mk(3'b101, 1, 1, 2'd0, 1, 3'b000, 1);
    tbl[23] = mk(3'b101, 0, 1, 2'd3, 0, 3'b000, 0);
    tbl[24] = mk(3'b101, 0, 1, 2'd0, 1, 3'b000, 0);
    tbl[25] = mk(3'b101, 0, 1, 2'd0, 1, 3'b000, 1);
    tbl[26] = mk(3'b000, 0, 1, 2'd0, 0, 3'b000, 1);
    tbl[27] = mk(3'b000, 0, 1, 2'd3, 0, 3'b001, 1);
    tbl[28] = mk(3'b000, 0, 1, 2'd3, 0, 3'b001, 1);
    tbl[29] = mk(3'b000, 0, 1, 2'd3, 0, 3'b000, 0);

    drive(3'b000, 1'b1);
    drive(3'b000, 1'b1);
    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].req, tbl[i].rs);
      if (tbl[i].ck) check_cycle($sformatf("tbl[%0d]", i), tbl[i].g, tbl[i].en, tbl[i].v, tbl[i].b);
    end

    // Hand-written: weight 2 beats then drops, feat takes over after one bubble.
    drive(3'b000, 1'b1);
    model_reset();
    drive(3'b100, 1'b0); model_step(1'b0);
    drive(3'b110, 1'b0); model_step(1'b0);
    drive(3'b110, 1'b0); model_step(1'b0);
    drive(3'b010, 1'b0); model_step(1'b0);
    for (int i = 0; i < 2; i++) begin drive(3'b010, 1'b0); model_step(1'b0); end
    for (int i = 0; i < 5; i++) begin drive(3'b000, 1'b0); model_step(1'b0); end

    // Random traffic: requesters mostly hold their request, occasional reset.
    cur = 3'b000;
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < 3; m++)
        cur[m] = cur[m] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 299) == 0);
      drive(cur, rs);
      model_step(rs);
    end

`ifdef ARB_PERF_CNT_EN
    @(posedge clk);
    #1;
    chk("perf_instr", 128'(perf_instr_beats), 128'(m_beats[0]));
    chk("perf_feat", 128'(perf_feat_beats), 128'(m_beats[1]));
    chk("perf_w", 128'(perf_w_beats), 128'(m_beats[2]));
    chk("perf_stall", 128'(perf_stall_cycles), 128'(m_stall));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_read_arbiter.md
Name: ddr_read_arbiter

Overview:
- Shares the single external read port (address/enable out, 128-bit data in) between three masters: instruction fetcher, feature fetcher and weight fetcher.
- Round-robin arbitration with burst locking.
- Tracks in-flight reads with a tag pipeline and steers each returned beat to the master that issued it.
- Sits between the fetch units and the off-chip data port inside top-level integration.

Parameters:
ADDR_WIDTH, 16, width of every address bus.
DATA_WIDTH, 128, width of the external data bus and of the feature return path.
NARROW_WIDTH, 64, width of the instruction and weight return paths; these carry mem_data[NARROW_WIDTH-1:0].
RD_LATENCY, 1, cycles from mem_rd_en to valid mem_data; legal range 1..4.
MAX_BURST, 16, maximum consecutive beats one master may issue before the grant rotates; must be >= 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
instr_req  input  1  instruction fetcher requests one read beat this cycle
instr_addr  input  ADDR_WIDTH  instruction read address
instr_data  output  NARROW_WIDTH  returned instruction word
instr_valid  output  1  instr_data valid
feat_req  input  1  feature fetcher read request
feat_addr  input  ADDR_WIDTH  feature read address
feat_data  output  DATA_WIDTH  returned feature beat
feat_valid  output  1  feat_data valid
w_req  input  1  weight/scaler fetcher read request
w_addr  input  ADDR_WIDTH  weight read address
w_data  output  NARROW_WIDTH  returned weight word
w_valid  output  1  w_data valid
mem_addr  output  ADDR_WIDTH  external read address
mem_rd_en  output  1  external read strobe
mem_data  input  DATA_WIDTH  external read data, valid RD_LATENCY cycles after mem_rd_en
grant_id  output  2  current owner: 0 = instr, 1 = feat, 2 = weight, 3 = none
busy  output  1  high while any read is in flight in the tag pipeline

Behaviour:
- Single clock, synchronous active-high reset.
- Reset values:
  - mem_rd_en = 0, mem_addr = 0.
  - All *_valid = 0; all data outputs = 0 while their valid is low.
  - grant_id = 3, busy = 0.
  - State IDLE, burst_cnt = 0.
  - last_owner = 2, so instr has first priority after reset.
  - Tag pipeline cleared.
- FSM states: IDLE, GRANT.
- Arbitration (evaluated at a clock edge when state == IDLE or a release condition holds):
  - Scan requesters starting at last_owner+1 mod 3.
  - The first requester with req high becomes owner: state -> GRANT, grant_id = owner, burst_cnt = 0.
  - If no requester is active: state -> IDLE, grant_id = 3.
- Beat issue:
  - In GRANT with req[owner] high, the beat is issued combinationally: mem_rd_en = 1, mem_addr = addr[owner], burst_cnt increments at the edge.
  - Non-owner requests are ignored; non-owners hold req until granted.
- Release condition (evaluated in GRANT):
  - req[owner] low in this cycle, or
  - a beat is issued with burst_cnt == MAX_BURST-1.
- On release:
  - last_owner = owner.
  - Re-arbitration happens at the same edge, so there is no idle cycle between owners.
  - If req drops, that cycle produces no beat (one bubble).
- Return path:
  - Tag pipeline of depth RD_LATENCY; each stage holds {vld, owner[1:0]}. Stage 0 is loaded with {mem_rd_en, owner} every cycle.
  - At the last stage: valid for the tagged owner = vld; data outputs take mem_data (low NARROW_WIDTH bits for instr/weight); all other valids are 0.
  - Order per master is preserved; a beat issued at cycle t returns at t+RD_LATENCY.
- busy = OR of all stage vld bits.
- Back-to-back owner change: beats of different owners interleave correctly in the pipeline with no lost or duplicated valid.
- Reset mid-burst: the pipeline is flushed; no valid is asserted for beats issued before reset.
- MAX_BURST = 1: pure per-beat round-robin.

Optional Feature:
ARB_PERF_CNT_EN
- Defined:
  - Adds three 32-bit saturating counters of issued beats per master, plus one 32-bit counter of cycles in which some req is high but no beat issues (stall).
  - Outputs: perf_instr_beats, perf_feat_beats, perf_w_beats, perf_stall_cycles; all 0 on reset; saturate at 0xFFFFFFFF.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then feat_req held with addr 0x0010..0x001F (16 beats), RD_LATENCY=1 -> mem_addr sequence 0x0010..0x001F on consecutive cycles; feat_valid on 16 consecutive cycles starting one cycle after first mem_rd_en; grant_id = 1.
- All three reqs high continuously, MAX_BURST=4 -> grant order instr, feat, weight, instr…; exactly 4 beats each, no idle cycle at handover.
- MAX_BURST=1, instr and weight high -> alternating beats I,W,I,W; each returned word appears only on the matching *_valid.
- RD_LATENCY=3, weight issues 2 beats, then feat issues 2 beats -> w_valid at cycles t+3, t+4; feat_valid at t+5, t+6; busy high from t+1 to t+6.
- Assert rst for one cycle while 2 beats are in flight -> no *_valid afterward; grant_id = 3; next grant goes to instr if requesting.
- ARB_PERF_CNT_EN defined: 10 instr beats with 2 stall cycles (req high, owner switching) -> perf_instr_beats = 10, perf_stall_cycles = 2.
